// File: rtl/mux_pkg.sv
// Shared types and flattened-bus helper for the registered round-robin mux family.
`default_nettype none

package mux_pkg;

  typedef enum logic {MODE_SEL = 1'b0, MODE_RR = 1'b1} mux_mode_t;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} mux_state_t;

  localparam int MUX_MAX_BUS = 1024;
  localparam int MUX_MAX_W   = 64;

  // Callers zero-extend the bus in and truncate the result to their own WIDTH.
  function automatic logic [MUX_MAX_W-1:0] chan_slice(input logic [MUX_MAX_BUS-1:0] d,
                                                      input int unsigned            i,
                                                      input int unsigned            w);
    logic [MUX_MAX_BUS-1:0] sh;
    sh = d >> (i * w);
    return sh[MUX_MAX_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo CHANNELS.
`default_nettype none

module rr_pick #(
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SELW-1:0]     last,
  output logic                hit,
  output logic [SELW-1:0]     idx
);

  logic [SELW-1:0] cand;

  // Walk from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      cand = SELW'((int'(last) + k) % CHANNELS);
      if (req[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_rr_reg.sv
// N-channel registered mux with explicit-index or round-robin selection and valid/ready on all sides.
// Optional macro MUX_PARITY_EN adds the registered z_parity output.
`default_nettype none

module mux_rr_reg
  import mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS-1:0]       d_valid,
  output logic [CHANNELS-1:0]       d_ready,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          z,
  output logic [SELW-1:0]           z_chan,
  output logic                      z_valid,
  input  logic                      z_ready
`ifdef MUX_PARITY_EN
  ,
  output logic                      z_parity
`endif
);

  localparam logic [SELW:0] CH_LIM = (SELW + 1)'(CHANNELS);

  mux_state_t      state, state_nxt;
  mux_mode_t       mode_e;
  logic [SELW-1:0] last, rr_idx, grant_idx;
  logic            rr_hit, sel_hit, grant_hit, load;
  logic [WIDTH-1:0] word;

  assign mode_e = mux_mode_t'(mode);

  rr_pick #(
    .CHANNELS (CHANNELS),
    .SELW     (SELW)
  ) u_rr_pick (
    .req  (d_valid),
    .last (last),
    .hit  (rr_hit),
    .idx  (rr_idx)
  );

  always_comb begin
    sel_hit = 1'b0;
    if ({1'b0, sel} < CH_LIM) sel_hit = d_valid[sel];
    if (mode_e == MODE_RR) begin
      grant_hit = rr_hit;
      grant_idx = rr_idx;
    end else begin
      grant_hit = sel_hit;
      grant_idx = sel;
    end
  end

  // A full register that is being drained may accept a new word in the same cycle.
  assign load = (state == EMPTY) || z_ready;

  always_comb begin
    d_ready = '0;
    if (load && grant_hit) d_ready[grant_idx] = 1'b1;
  end

  assign word = WIDTH'(chan_slice(MUX_MAX_BUS'(d), 32'(grant_idx), 32'(WIDTH)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load) state_nxt = grant_hit ? FULL : EMPTY;
  end

  assign z_valid = (state == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z      <= '0;
      z_chan <= '0;
      last   <= SELW'(CHANNELS - 1);
    end else if (load && grant_hit) begin
      z      <= word;
      z_chan <= grant_idx;
      if (mode_e == MODE_RR) last <= grant_idx;
    end
  end

`ifdef MUX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    z_parity <= 1'b0;
    else if (load && grant_hit) z_parity <= ^word;
  end
`endif

endmodule

`default_nettype wire

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
Parametrised N-channel, W-bit registered multiplexer with valid/ready handshake on every input channel and on the output. Successor to the 2:1 gate-level mux used in the ALU datapath. Selects either the explicitly indexed channel or the next requester in round-robin order. The result is held in a one-entry output register with full-throughput pass-through. Sits between the ALU operand sources and the operand/result registers.

Parameters:
WIDTH, 8, data bits per channel (>=1)
CHANNELS, 4, number of input channels (>=2, need not be a power of 2)
SELW, $clog2(CHANNELS), derived width of channel index; not to be overridden

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
d  input  CHANNELS*WIDTH  flattened channel data; channel i at bits [i*WIDTH +: WIDTH]
d_valid  input  CHANNELS  per-channel request
d_ready  output  CHANNELS  per-channel accept (one-hot or zero)
mode  input  1  0 = MODE_SEL (explicit index), 1 = MODE_RR (round-robin)
sel  input  SELW  channel index used in MODE_SEL
z  output  WIDTH  registered selected data
z_chan  output  SELW  index of the channel that produced z
z_valid  output  1  z/z_chan hold a valid word
z_ready  input  1  downstream accept

Behaviour:
- Reset (async assert, sync release): z=0, z_chan=0, z_valid=0, state=EMPTY, rr pointer last=CHANNELS-1, so channel 0 has first priority.
- FSM: EMPTY (z_valid=0) and FULL (z_valid=1).
- load = (state==EMPTY) | z_ready. This is combinational, so a full register drains and refills in the same cycle (full throughput).
- Grant, combinational:
  - MODE_SEL: grant channel sel iff sel<CHANNELS and d_valid[sel]. If sel>=CHANNELS, no grant.
  - MODE_RR: first i with d_valid[i], searching from last+1 upward and wrapping modulo CHANNELS.
- d_ready[g] = load & grant_hit, only for the granted g. All other bits are 0. d_ready never depends on z_valid of other channels.
- Transfer on an edge where load & grant_hit: z<=d[g], z_chan<=g, z_valid<=1, state->FULL. In MODE_RR, last<=g.
- On an edge with load & !grant_hit: z_valid<=0, state->EMPTY. z and z_chan keep their old values (don't-care).
- FULL & !z_ready: z, z_chan and z_valid stay stable. Every d_ready bit is 0.
- Latency: one cycle from input handshake to z_valid. Sustained rate: one word per cycle.
- The rr pointer updates only on an RR grant. MODE_SEL grants leave it unchanged.
- A mode or sel change takes effect at the next load cycle. It never alters held output.
- Fairness: with all channels requesting continuously in MODE_RR, each channel is granted once every CHANNELS transfers.
- Reset mid-transfer: the held word is discarded and the pointer returns to CHANNELS-1.
- Inputs must not depend combinationally on d_ready. This rules out loops with upstream.

Optional Feature:
MUX_PARITY_EN
- Defined: adds output port z_parity (1 bit) = XOR of the selected d word. It is registered alongside z, with reset value 0 and the same hold rules.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Package mux_pkg:
  - typedef enum logic {MODE_SEL, MODE_RR} mux_mode_t
  - typedef enum logic {EMPTY, FULL} mux_state_t
  - function chan_slice(d, i) for flattened-bus extraction
- Sub-module rr_pick: combinational round-robin priority picker, parametrised by CHANNELS.
  - Inputs: req[CHANNELS], last[SELW]
  - Outputs: hit, idx[SELW]
  - Reused later by the ALU operand arbiter.

Test Plan:
- Reset: with rst high, check z=0, z_chan=0, z_valid=0, d_ready=0. After release with d_valid=4'b1111, mode=RR and z_ready=1, grants run 0,1,2,3,0 on consecutive cycles, with z=d[ch] one cycle later.
- MODE_SEL, CHANNELS=4:
  - sel=2, d_valid=4'b0100, d[2]=8'hA5: d_ready=4'b0100, next cycle z=8'hA5, z_chan=2.
  - sel=2 with d_valid=4'b1011: no grant and z_valid drops.
- Backpressure: hold z_ready=0 for 3 cycles with z_valid=1. z, z_chan and z_valid stay stable and d_ready=0. Raise z_ready with d_valid[1]=1: drain and reload in the same cycle, with no bubble.
- RR skip and wrap: last=2, d_valid=4'b0011 gives grant 0. Then last=0, d_valid=4'b0010 gives grant 1. With CHANNELS=3, sel=3 in MODE_SEL never grants.
- Async reset mid-stream: assert rst between edges while FULL. z_valid drops immediately without a clock, and the next RR grant after release is channel 0.
- MUX_PARITY_EN: d[1]=8'h07 selected gives z_parity=1; 8'h03 gives z_parity=0. Build without the macro and confirm the port is absent and the other tests pass unchanged.
